// File: rtl/eclk_sequencer.sv
// eclk_sequencer: bus-timing sequencer on the 28 MHz master clock.
// Generates bus-clock phases (c1/c3), the bus enable, the colour clock, the
// E-clock level and its one-hot slot decode. With ECLK_SEQ_HANDSHAKE_EN
// defined it also provides the VPA -> VMA/DTACK handshake that aligns
// CIA-style accesses with the E-clock; otherwise vma/dtack_e stay low.
module eclk_sequencer #(
  parameter int unsigned PHASES = 4,
  parameter int unsigned E_DIV  = 10,
  parameter int unsigned E_HIGH = 4
) (
  input  logic             clk28m,
  input  logic             reset,
  output logic             c1,
  output logic             c3,
  output logic             bus_en,
  output logic             cck,
  output logic [E_DIV-1:0] eclk,
  output logic             e,
  input  logic             vpa_req,
  output logic             vma,
  output logic             dtack_e
);

  localparam int unsigned PW = $clog2(PHASES);
  localparam int unsigned EW = $clog2(E_DIV);

  localparam logic [PW-1:0] PLast  = PW'(PHASES - 1);
  localparam logic [PW-1:0] PHalf  = PW'(PHASES / 2);
  localparam logic [EW-1:0] ELast  = EW'(E_DIV - 1);
  localparam logic [EW-1:0] EStart = EW'(E_DIV - E_HIGH);
  localparam logic [EW-1:0] EPre   = EW'(E_DIV - E_HIGH - 1);

  logic [PW-1:0] p_q;
  logic [EW-1:0] e_cnt_q;

  // Phase counter: one step per master clock, wraps each bus cycle.
  always_ff @(posedge clk28m) begin
    if (reset) begin
      p_q <= '0;
    end else if (p_q == PLast) begin
      p_q <= '0;
    end else begin
      p_q <= p_q + 1'b1;
    end
  end

  // E counter: one step per bus cycle, wraps each E period.
  always_ff @(posedge clk28m) begin
    if (reset) begin
      e_cnt_q <= '0;
    end else if (bus_en) begin
      e_cnt_q <= (e_cnt_q == ELast) ? '0 : e_cnt_q + 1'b1;
    end
  end

  // Clock and enable decodes straight from the registered counters.
  always_comb begin
    c1     = (p_q < PHalf);
    c3     = (p_q != '0) && (p_q <= PHalf);
    bus_en = (p_q == PLast);
    cck    = ~e_cnt_q[0];
    e      = (e_cnt_q >= EStart);
    eclk   = {{(E_DIV - 1){1'b0}}, 1'b1} << e_cnt_q;
  end

`ifdef ECLK_SEQ_HANDSHAKE_EN

  typedef enum logic [1:0] {StIdle, StSync, StAccess, StRelease} state_e;

  state_e state_q, state_d;
  logic   vma_q, vma_d;
  logic   dtack_q, dtack_d;

  // Handshake next state: only evaluated on bus_en, so vma tracks e exactly
  // and a request seen on the last pre-window slot waits a whole period.
  always_comb begin
    state_d = state_q;
    vma_d   = vma_q;
    dtack_d = dtack_q;
    if (bus_en) begin
      case (state_q)
        StIdle: begin
          if (vpa_req) state_d = StSync;
        end
        StSync: begin
          if (e_cnt_q == EPre) begin
            state_d = StAccess;
            vma_d   = 1'b1;
          end
        end
        StAccess: begin
          if (e_cnt_q == ELast) begin
            state_d = StRelease;
            vma_d   = 1'b0;
            dtack_d = 1'b1;
          end
        end
        StRelease: begin
          dtack_d = 1'b0;
          if (!vpa_req) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Handshake state and registered outputs.
  always_ff @(posedge clk28m) begin
    if (reset) begin
      state_q <= StIdle;
      vma_q   <= 1'b0;
      dtack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vma_q   <= vma_d;
      dtack_q <= dtack_d;
    end
  end

  assign vma     = vma_q;
  assign dtack_e = dtack_q;

`else

  logic unused_vpa_req;
  assign unused_vpa_req = vpa_req;
  assign vma            = 1'b0;
  assign dtack_e        = 1'b0;

`endif

endmodule
